rca_seq_adder: RTL and testbench
================================

# rca_seq_adder

Sequencing controller that time-multiplexes one 4-bit ripple-carry adder to add two wide operands nibble by nibble, least significant first. The inter-nibble carry is held in a register between cycles. It sits between a requesting unit (start/done handshake) and the shared 4-bit adder datapath, trading latency for area on wide additions.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy is low.
- a  in  W  operand A; sampled on the accepting edge.
- b  in  W  operand B; sampled on the accepting edge.
- cin  in  1  carry into nibble 0; sampled on the accepting edge.
- op_sub  in  1  subtract select; present only with RCA_SEQ_SUB_EN.
- busy  out  1  high from the accepting edge until the edge that leaves DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result; registered, held until the next done.
- cout  out  1  carry out of the top nibble; registered with sum.

## Operation
- FSM states:
  - IDLE: busy=0. On start=1, latch a, b and carry_q<=cin, clear idx, go to RUN.
  - RUN: adder x=a_q[4*idx+:4], y=b_q[4*idx+:4], cin=carry_q. Each edge writes acc[4*idx+:4]<=adder sum, carry_q<=adder cout, idx<=idx+1. When idx==NIBBLES-1, load sum<={adder sum, acc lower bits} and cout<=adder cout, then go to DONE.
  - DONE: done=1, busy=1. Unconditional return to IDLE.
- Arithmetic: modulo 2^W unsigned. cout is the true carry out of bit W-1. No sign handling.
- idx is ceil(log2(NIBBLES)) bits wide. It never exceeds NIBBLES-1.
- start while busy=1: ignored, with no queuing. start held high continuously: a new operation is accepted on the first edge back in IDLE.
- Operand inputs may change freely after the accepting edge; only the latched copies are used.
- Reset, asynchronous and including mid-operation: state=IDLE, idx=0, carry_q=0, a_q=b_q=acc=0, sum=0, cout=0, busy=0, done=0. An aborted operation never produces done.

## Timing
- Accepting edge is T0. Nibble i is added between edges T0+i and T0+i+1.
- sum/cout update and done rises at edge T0+NIBBLES. done falls at T0+NIBBLES+1.
- Latency start-to-done: NIBBLES cycles.
- Throughput: one operation per NIBBLES+2 cycles when start is held high.
- busy and done are registered outputs, with no combinational path from start.
- Combinational critical path: one 4-bit ripple, from carry_q through adder to acc.

## Configuration
- RCA_SEQ_SUB_EN defined: op_sub port exists and is latched with the operands.
  - When op_sub=1: y = ~b_q nibble, carry_q is initialised to 1, and cin is ignored.
  - Result is a-b mod 2^W. cout=1 means no borrow (a>=b).
- RCA_SEQ_SUB_EN undefined: op_sub port and inversion logic are absent; addition only.

## Structure
- Shared package rca_seq_pkg holds:
  - NIBBLE_W=4.
  - State typedef enum {IDLE, RUN, DONE}, 2-bit encoding.
- One sub-module: the team's existing RCAdder_4bit (ports x, y, cin, sum, cout), instantiated once as the shared datapath.
- The controller holds FSM, index counter, carry register, operand latches, accumulator and output registers. It contains no adder logic of its own.

## Test plan
- NIBBLES=4, 0x1234+0x0FCD, cin=0 -> sum=0x2201, cout=0. done is high exactly 4 cycles after the accepting edge, for 1 cycle.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through every nibble register). Also 0xCAFE+0x1234, cin=1 -> 0xDD33, cout=0.
- Pulse start with new operands during RUN and during DONE -> ignored. Result equals the first operation; only one done pulse.
- Assert rst at T0+2 mid-RUN -> busy, done, sum and cout are 0 immediately. No done follows. The next start completes normally.
- start held high for 20 cycles with fixed operands -> done pulses every 6 cycles, each with the correct result.
- RCA_SEQ_SUB_EN: 0x0007-0x0005 -> 0x0002, cout=1. 0x0005-0x0007 -> 0xFFFE, cout=0. cin is ignored in both cases.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared constants and FSM state type for the sequential ripple-carry adder
package rca_seq_pkg;

  // Width of one slice handled by the shared adder per cycle
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/RCAdder_4bit.sv
// rtl/RCAdder_4bit.sv - 4-bit ripple-carry adder used as the shared datapath slice
module RCAdder_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c;

  // Ripple the carry through four full-adder bits, LSB first
  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - nibble-serial wide adder controller; RCA_SEQ_SUB_EN adds op_sub subtraction
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic         op_sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state;
  state_t state_nx;

  logic [IDX_W-1:0]                   idx;
  logic                               carry_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc_nx;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
  logic                               cout_q;
  logic                               last;

  logic [NIBBLE_W-1:0] add_x;
  logic [NIBBLE_W-1:0] add_y;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

`ifdef RCA_SEQ_SUB_EN
  logic sub_q;
`endif

  assign last = (idx == LAST_IDX);

  // Select the current operand slices for the shared adder
  always_comb begin
    add_x = a_q[idx];
`ifdef RCA_SEQ_SUB_EN
    add_y = sub_q ? ~b_q[idx] : b_q[idx];
`else
    add_y = b_q[idx];
`endif
  end

  RCAdder_4bit u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Accumulator with the current slice merged in; also the final result image
  always_comb begin
    acc_nx      = acc;
    acc_nx[idx] = add_sum;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: accept only from IDLE, DONE always lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latches, slice counter, carry chain register and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx     <= '0;
`ifdef RCA_SEQ_SUB_EN
            // Two's complement subtract: invert b slices and inject a carry of one
            sub_q   <= op_sub;
            carry_q <= op_sub | cin;
`else
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          acc     <= acc_nx;
          carry_q <= add_cout;
          if (last) begin
            idx    <= '0;
            sum_q  <= acc_nx;
            cout_q <= add_cout;
          end else begin
            idx    <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - scoreboard bench for rca_seq_adder; covers RCA_SEQ_SUB_EN when defined
module tb_rca_seq_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         sub_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int exp_dones = 0;
  logic done_prev = 1'b0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  rca_seq_adder #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .cin    (cin_in),
`ifdef RCA_SEQ_SUB_EN
    .op_sub (sub_in),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
`ifdef RCA_SEQ_SUB_EN
    exp_q.push_back(model(x, y, c, s));
`else
    exp_q.push_back(model(x, y, c, 1'b0));
`endif
    exp_dones++;
  endtask

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check("done_width", {63'd0, done_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sum", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, e[W-1:0]});
        check("cout", {63'd0, cout}, {63'd0, e[W]});
      end
    end
    done_prev = done;
  end

  // One operation with exact latency checks; operand inputs scrambled after acceptance
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    @(negedge clk);
    start = 1'b1; a_in = x; b_in = y; cin_in = c; sub_in = s;
    push_exp(x, y, c, s);
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin_in = ~c; sub_in = ~s;
    check("busy_run", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      check("done_time", {63'd0, done}, {63'd0, (k == N)});
    end
    @(negedge clk);
    check("done_fall", {63'd0, done}, 64'd0);
    check("busy_fall", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'hCAFE, 16'h1234, 1'b1, 1'b0);

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b0; sub_in = 1'b0;
    push_exp(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      if (k == 1 || k == N) begin
        start = 1'b1; a_in = 16'h9999; b_in = 16'h8888; cin_in = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ignore_idle", {63'd0, busy}, 64'd0);
    repeat (N + 2) @(negedge clk);

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    start = 1'b1; a_in = 16'h4321; b_in = 16'h1111; cin_in = 1'b0;
    push_exp(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    check("abort_cout", {63'd0, cout}, 64'd0);
    void'(exp_q.pop_back());
    exp_dones--;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      check("abort_nodone", {63'd0, done}, 64'd0);
    end
    do_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);

    // start held high: one accept every N+2 cycles
    @(negedge clk);
    start = 1'b1; a_in = 16'hA5A5; b_in = 16'h5A5B; cin_in = 1'b1; sub_in = 1'b0;
    push_exp(16'hA5A5, 16'h5A5B, 1'b1, 1'b0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check("hold_done", {63'd0, done}, {63'd0, ((c % (N + 2)) == N)});
      if (((c + 1) % (N + 2)) == 0 && (c + 1) < 20)
        push_exp(16'hA5A5, 16'h5A5B, 1'b1, 1'b0);
      if (c == 19) start = 1'b0;
    end

`ifdef RCA_SEQ_SUB_EN
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
`endif

    repeat (2) @(negedge clk);
    check("done_count", 64'(done_count), 64'(exp_dones));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
